// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory pipeline stage (master) and data memory (slave).
// Request side is held stable by the master from request until ack.
interface mem_stage_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    input  dmem_rdata_i, dmem_ack_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    output dmem_rdata_i, dmem_ack_i
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: steers loads/stores onto the data bus with req/ack,
// extracts and extends load lanes, forwards ALU results and stalls upstream while busy.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rstl,
  input  logic [10:0] opcode_exe_2_mem_i,
  input  logic [4:0]  rd_exe_2_mem_i,
  input  logic [31:0] rd_data_exe_2_mem_i,
  input  logic [31:0] mem_data_i,
  input  logic        load_valid_i,
  input  logic        store_valid_i,
  mem_stage_if.master dmem,
  output logic        stall_o,
  output logic [4:0]  rd_mem_2_wb_o,
  output logic [31:0] rd_data_mem_2_wb_o,
  output logic        wb_en_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} sz_e;

  function automatic sz_e access_size(input logic is_store, input logic [2:0] f3);
    sz_e sz;
    if (is_store) begin
      case (f3)
        3'b010:  sz = SZ_BYTE;
        3'b001:  sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (f3[1:0])
        2'b00:   sz = SZ_BYTE;
        2'b01:   sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic [3:0] byte_enable(input sz_e sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input sz_e sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [31:0] s;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (access_size(1'b0, f3))
      SZ_BYTE: s = f3[2] ? signed'({24'd0, b}) : 32'(signed'(b));
      SZ_HALF: s = f3[2] ? signed'({16'd0, h}) : 32'(signed'(h));
      default: s = signed'(rdata);
    endcase
    return unsigned'(s);
  endfunction

  state_e      r_state;
  state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0]  r_f3_p1;
  logic [4:0]  r_rd_p1;
  logic [1:0]  r_off_p1;
  logic        r_we_p1;
  logic [31:0] r_addr_p1;
  logic [31:0] r_wdata_p1;
  logic [3:0]  r_be_p1;

  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_wb_en;
  logic        r_misalign;
  logic        r_bus_err;

  logic [2:0]  w_f3;
  logic [1:0]  w_off;
  logic        w_access;
  logic        w_is_store;
  sz_e         w_size;
  logic        w_misalign;
  logic        w_accept;
  logic [31:0] w_word_addr;
  logic [31:0] w_wdata_new;
  logic [3:0]  w_be_new;
  logic        w_alu_op;
  logic        w_alu_wb;
  logic        w_tmo;
  logic        w_done;
  logic        w_req;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic        w_stall;
  logic        w_unused;

  assign w_f3        = opcode_exe_2_mem_i[9:7];
  assign w_off       = rd_data_exe_2_mem_i[1:0];
  assign w_access    = load_valid_i | store_valid_i;
  assign w_is_store  = store_valid_i;
  assign w_size      = access_size(w_is_store, w_f3);
  assign w_misalign  = ((w_size == SZ_HALF) & w_off[0]) | ((w_size == SZ_WORD) & (|w_off));
  assign w_accept    = w_access & ~w_misalign;
  assign w_word_addr = {rd_data_exe_2_mem_i[31:2], 2'b00};
  assign w_wdata_new = w_is_store ? store_data(w_size, mem_data_i) : 32'd0;
  assign w_be_new    = byte_enable(w_size, w_off);
  assign w_unused    = opcode_exe_2_mem_i[10];

  always_comb begin
    case (opcode_exe_2_mem_i[6:0])
      7'b0110011, 7'b0010011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: w_alu_op = 1'b1;
      default:                            w_alu_op = 1'b0;
    endcase
  end
  assign w_alu_wb = w_alu_op & (|rd_exe_2_mem_i);

  // An ack in the timeout cycle is still taken as completion.
  assign w_tmo  = (r_cnt == CNT_W'(TIMEOUT));
  assign w_done = dmem.dmem_ack_i | w_tmo;

  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Bus drive is gated by rstl so a held upstream request cannot leak out during reset.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_we        = 1'b0;
    w_addr      = 32'd0;
    w_wdata     = 32'd0;
    w_be        = 4'd0;
    w_stall     = 1'b0;
    if (rstl) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_req       = 1'b1;
            w_stall     = 1'b1;
            w_we        = w_is_store;
            w_addr      = w_word_addr;
            w_wdata     = w_wdata_new;
            w_be        = w_be_new;
            w_state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          w_we    = r_we_p1;
          w_addr  = r_addr_p1;
          w_wdata = r_wdata_p1;
          w_be    = r_be_p1;
          w_req   = ~w_done;
          w_stall = ~w_done;
          if (w_done) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // p1: transaction captured at acceptance, held for the whole WAIT.
  always_ff @(posedge clk) begin
    if ((r_state == ST_IDLE) && w_accept) begin
      r_f3_p1    <= w_f3;
      r_rd_p1    <= rd_exe_2_mem_i;
      r_off_p1   <= w_off;
      r_we_p1    <= w_is_store;
      r_addr_p1  <= w_word_addr;
      r_wdata_p1 <= w_wdata_new;
      r_be_p1    <= w_be_new;
    end
  end

  // Write-back bundle and status pulses, registered towards WB.
  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      r_cnt      <= '0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 32'd0;
      r_wb_en    <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_wb_en    <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_access) begin
            r_misalign <= w_misalign;
          end else begin
            r_wb_rd   <= rd_exe_2_mem_i;
            r_wb_data <= rd_data_exe_2_mem_i;
            r_wb_en   <= w_alu_wb;
          end
        end
        ST_WAIT: begin
          if (dmem.dmem_ack_i) begin
            r_cnt <= '0;
            if (!r_we_p1) begin
              r_wb_rd   <= r_rd_p1;
              r_wb_data <= load_extend(r_f3_p1, r_off_p1, dmem.dmem_rdata_i);
              r_wb_en   <= |r_rd_p1;
            end
          end else if (w_tmo) begin
            r_cnt     <= '0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign dmem.dmem_req_o   = w_req;
  assign dmem.dmem_we_o    = w_we;
  assign dmem.dmem_addr_o  = w_addr;
  assign dmem.dmem_wdata_o = w_wdata;
  assign dmem.dmem_be_o    = w_be;
  assign stall_o            = w_stall;
  assign rd_mem_2_wb_o      = r_wb_rd;
  assign rd_data_mem_2_wb_o = r_wb_data;
  assign wb_en_o            = r_wb_en;
  assign misalign_o         = r_misalign;
  assign bus_err_o          = r_bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed spec cases plus randomized ALU/load/store traffic
// checked against a byte-arithmetic reference model of the memory stage.
module tb_mem_stage;
  localparam int TIMEOUT = 16;
  localparam logic [6:0] OPS [8] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                                     7'b1101111, 7'b1100111, 7'b0000011, 7'b1100011};
  localparam logic [2:0] LF3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  logic        clk = 1'b0;
  logic        rstl;
  logic [10:0] opc;
  logic [4:0]  rd_in;
  logic [31:0] rdd, md;
  logic        lv, sv;
  logic        stall, wb_en, mis, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mem_stage_if bus();

  mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rstl(rstl),
    .opcode_exe_2_mem_i(opc), .rd_exe_2_mem_i(rd_in), .rd_data_exe_2_mem_i(rdd),
    .mem_data_i(md), .load_valid_i(lv), .store_valid_i(sv),
    .dmem(bus),
    .stall_o(stall), .rd_mem_2_wb_o(wb_rd), .rd_data_mem_2_wb_o(wb_data),
    .wb_en_o(wb_en), .misalign_o(mis), .bus_err_o(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        o_req, o_we, o_stable, o_req_seen, o_req_end, o_pulse2;
  logic [31:0] o_addr, o_wdata, o_wb_data;
  logic [3:0]  o_be;
  logic [4:0]  o_wb_rd;
  logic        o_wb_en, o_mis, o_err;
  int          o_stall_n;

  // ---------------- reference model ----------------
  function automatic int m_nbytes(input logic st, input logic [2:0] f3);
    int n;
    if (st) begin
      case (f3) 3'b010: n = 1; 3'b001: n = 2; default: n = 4; endcase
    end else begin
      case (f3) 3'b000, 3'b100: n = 1; 3'b001, 3'b101: n = 2; default: n = 4; endcase
    end
    return n;
  endfunction

  function automatic logic [3:0] m_be(input int n, input logic [31:0] addr);
    int v;
    v = ((1 << n) - 1) << int'(addr % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input int n, input logic [31:0] sd);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdat);
    int n;
    logic [31:0] mask, v;
    n = m_nbytes(1'b0, f3);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*n)) - 32'h1);
    v = (rdat >> (8*int'(addr % 4))) & mask;
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Drives one memory instruction as a holding upstream would, plays the memory
  // (ack on WAIT cycle ack_k, 0 = never) and records what the DUT showed.
  task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [31:0] rdat, input int ack_k);
    int k;
    @(posedge clk); #1;
    opc = {1'b0, f3, (st ? 7'b0100011 : 7'b0000011)};
    rd_in = rd; rdd = addr; md = sd; lv = ld; sv = st;
    bus.dmem_ack_i = 1'b0; bus.dmem_rdata_i = $urandom;
    #1;
    o_req = bus.dmem_req_o; o_we = bus.dmem_we_o; o_addr = bus.dmem_addr_o;
    o_wdata = bus.dmem_wdata_o; o_be = bus.dmem_be_o;
    o_stall_n = stall ? 1 : 0; o_stable = 1'b1; o_req_seen = bus.dmem_req_o;
    o_req_end = bus.dmem_req_o;
    if (stall) begin
      k = 0;
      do begin
        @(posedge clk); #1; k++;
        bus.dmem_ack_i = (k == ack_k);
        bus.dmem_rdata_i = (k == ack_k) ? rdat : $urandom;
        #1;
        if (stall) begin
          o_stall_n++;
          if (!(bus.dmem_req_o === 1'b1 && bus.dmem_we_o === o_we && bus.dmem_addr_o === o_addr &&
                bus.dmem_wdata_o === o_wdata && bus.dmem_be_o === o_be)) o_stable = 1'b0;
        end
        if (bus.dmem_req_o) o_req_seen = 1'b1;
        o_req_end = bus.dmem_req_o;
      end while (stall && k < TIMEOUT + 8);
      if (stall) begin
        total++; bad++;
        $display("FAIL txn_bound stall still high after %0d cycles, required release", k);
      end
    end
    @(posedge clk); #1;
    lv = 1'b0; sv = 1'b0; opc = 11'd0; rd_in = 5'd0; rdd = 32'd0; md = 32'd0;
    bus.dmem_ack_i = 1'b0;
    #1;
    o_wb_en = wb_en; o_wb_rd = wb_rd; o_wb_data = wb_data; o_mis = mis; o_err = err;
    if (bus.dmem_req_o) o_req_seen = 1'b1;
    @(posedge clk); #2;
    o_pulse2 = wb_en | mis | err;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstl = 1'b0; opc = 11'd0; rd_in = 5'd0; rdd = 32'd0; md = 32'd0; lv = 1'b0; sv = 1'b0;
    bus.dmem_ack_i = 1'b0; bus.dmem_rdata_i = 32'd0;
    #3;
    total++;
    if ({stall, bus.dmem_req_o, bus.dmem_we_o, bus.dmem_addr_o, bus.dmem_wdata_o, bus.dmem_be_o,
         wb_en, mis, err, wb_rd, wb_data} !== '0) begin
      bad++; $display("FAIL reset_outputs got nonzero stall=%b req=%b wb_en=%b, required all 0",
                      stall, bus.dmem_req_o, wb_en);
    end
    opc = {1'b0, 3'b010, 7'b0000011}; rdd = 32'h40; rd_in = 5'd3; lv = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({stall, bus.dmem_req_o, bus.dmem_be_o, bus.dmem_addr_o} !== '0) begin
      bad++; $display("FAIL reset_load_held got stall=%b req=%b, required 0", stall, bus.dmem_req_o);
    end
    lv = 1'b0; opc = 11'd0; rdd = 32'd0; rd_in = 5'd0;
    @(posedge clk); #1; rstl = 1'b1;
  endtask

  task automatic test_alu();
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        pen;
    int          sel;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        total++;
        if (wb_en !== pen) begin bad++; $display("FAIL alu_wb_en[%0d] got=%b exp=%b", i, wb_en, pen); end
        total++;
        if ({wb_rd, wb_data} !== {prd, pdata}) begin
          bad++; $display("FAIL alu_wb[%0d] got rd=%0d data=%h exp rd=%0d data=%h", i, wb_rd, wb_data, prd, pdata);
        end
      end
      if (i == 0) begin
        sel = 0; prd = 5'd5; pdata = 32'h0000_1234;
      end else begin
        sel = $urandom_range(0, 7); prd = 5'($urandom_range(0, 31)); pdata = $urandom;
      end
      opc = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), OPS[sel]};
      if (i == 0) opc = {1'b0, 3'b000, 7'b0110011};
      rd_in = prd; rdd = pdata; lv = 1'b0; sv = 1'b0;
      bus.dmem_ack_i = 1'($urandom_range(0, 1));
      pen = (prd != 5'd0) && (sel < 6);
      #1;
      total++;
      if ({stall, bus.dmem_req_o} !== 2'b00) begin
        bad++; $display("FAIL alu_nostall[%0d] got stall=%b req=%b, required 0", i, stall, bus.dmem_req_o);
      end
    end
    @(posedge clk); #1;
    opc = 11'd0; rd_in = 5'd0; rdd = 32'd0; bus.dmem_ack_i = 1'b0;
    total++;
    if ({wb_en, wb_rd, wb_data} !== {pen, prd, pdata}) begin
      bad++; $display("FAIL alu_last got en=%b rd=%0d data=%h exp en=%b rd=%0d data=%h",
                      wb_en, wb_rd, wb_data, pen, prd, pdata);
    end
  endtask

  task automatic test_load();
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr, rdat;
    int          n, ak;
    run_txn(1'b1, 1'b0, 3'b000, 5'd7, 32'h103, 32'd0, 32'h80FF_0000, 2);
    total++;
    if ({o_req, o_we, o_be, o_addr} !== {1'b1, 1'b0, 4'b1000, 32'h100}) begin
      bad++; $display("FAIL lb_bus got req=%b we=%b be=%b addr=%h exp 1 0 1000 00000100", o_req, o_we, o_be, o_addr);
    end
    total++;
    if ({o_wb_en, o_wb_rd, o_wb_data} !== {1'b1, 5'd7, 32'hFFFF_FF80}) begin
      bad++; $display("FAIL lb_wb got en=%b rd=%0d data=%h exp 1 7 ffffff80", o_wb_en, o_wb_rd, o_wb_data);
    end
    total++;
    if (o_stall_n !== 2) begin bad++; $display("FAIL lb_stall_cycles got=%0d exp=2", o_stall_n); end
    total++;
    if ({o_stable, o_req_end, o_pulse2} !== 3'b100) begin
      bad++; $display("FAIL lb_hold got stable=%b req_at_ack=%b pulse2=%b exp 1 0 0", o_stable, o_req_end, o_pulse2);
    end
    run_txn(1'b1, 1'b0, 3'b101, 5'd9, 32'h202, 32'd0, 32'hBEEF_1234, 1);
    total++;
    if ({o_be, o_wb_en, o_wb_data} !== {4'b1100, 1'b1, 32'h0000_BEEF}) begin
      bad++; $display("FAIL lhu got be=%b en=%b data=%h exp 1100 1 0000beef", o_be, o_wb_en, o_wb_data);
    end
    run_txn(1'b1, 1'b0, 3'b010, 5'd0, 32'h300, 32'd0, 32'h1234_5678, 1);
    total++;
    if (o_wb_en !== 1'b0) begin bad++; $display("FAIL lw_rd0 got wb_en=%b exp=0", o_wb_en); end
    for (int i = 0; i < 12; i++) begin
      f3 = LF3[$urandom_range(0, 4)]; n = m_nbytes(1'b0, f3);
      addr = $urandom; addr = addr - (addr % n);
      rd = 5'($urandom_range(1, 31)); rdat = $urandom; ak = $urandom_range(1, 5);
      run_txn(1'b1, 1'b0, f3, rd, addr, $urandom, rdat, ak);
      total++;
      if ({o_req, o_we, o_be, o_addr} !== {1'b1, 1'b0, m_be(n, addr), addr & 32'hFFFF_FFFC}) begin
        bad++; $display("FAIL ld_rand_bus[%0d] got be=%b addr=%h exp be=%b addr=%h", i, o_be, o_addr, m_be(n, addr), addr & 32'hFFFF_FFFC);
      end
      total++;
      if ({o_wb_en, o_wb_rd, o_wb_data} !== {1'b1, rd, m_load(f3, addr, rdat)}) begin
        bad++; $display("FAIL ld_rand_wb[%0d] f3=%b got en=%b data=%h exp data=%h", i, f3, o_wb_en, o_wb_data, m_load(f3, addr, rdat));
      end
      total++;
      if (o_stall_n !== ak || o_stable !== 1'b1) begin
        bad++; $display("FAIL ld_rand_stall[%0d] got cycles=%0d stable=%b exp cycles=%0d stable=1", i, o_stall_n, o_stable, ak);
      end
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3;
    logic [31:0] addr, sd;
    int          n, ak;
    run_txn(1'b0, 1'b1, 3'b001, 5'd4, 32'h302, 32'h0000_ABCD, 32'd0, 3);
    total++;
    if ({o_we, o_be, o_wdata, o_addr} !== {1'b1, 4'b1100, 32'hABCD_ABCD, 32'h300}) begin
      bad++; $display("FAIL sh_bus got we=%b be=%b wdata=%h addr=%h exp 1 1100 abcdabcd 00000300", o_we, o_be, o_wdata, o_addr);
    end
    total++;
    if ({o_stable, o_wb_en} !== 2'b10 || o_stall_n !== 3) begin
      bad++; $display("FAIL sh_hold got stable=%b wb_en=%b cycles=%0d exp 1 0 3", o_stable, o_wb_en, o_stall_n);
    end
    run_txn(1'b1, 1'b1, 3'b000, 5'd6, 32'h44, 32'h1122_3344, 32'd0, 1);
    total++;
    if ({o_we, o_be, o_wdata, o_wb_en} !== {1'b1, 4'b1111, 32'h1122_3344, 1'b0}) begin
      bad++; $display("FAIL both_valid got we=%b be=%b wdata=%h wb_en=%b exp 1 1111 11223344 0", o_we, o_be, o_wdata, o_wb_en);
    end
    for (int i = 0; i < 10; i++) begin
      f3 = 3'($urandom_range(0, 2)); n = m_nbytes(1'b1, f3);
      addr = $urandom; addr = addr - (addr % n); sd = $urandom; ak = $urandom_range(1, 5);
      run_txn(1'b0, 1'b1, f3, 5'($urandom_range(0, 31)), addr, sd, $urandom, ak);
      total++;
      if ({o_we, o_be, o_wdata, o_addr} !== {1'b1, m_be(n, addr), m_wdata(n, sd), addr & 32'hFFFF_FFFC}) begin
        bad++; $display("FAIL st_rand_bus[%0d] f3=%b got be=%b wdata=%h exp be=%b wdata=%h", i, f3, o_be, o_wdata, m_be(n, addr), m_wdata(n, sd));
      end
      total++;
      if (o_wb_en !== 1'b0 || o_stall_n !== ak || o_stable !== 1'b1) begin
        bad++; $display("FAIL st_rand_ctl[%0d] got wb_en=%b cycles=%0d stable=%b exp 0 %0d 1", i, o_wb_en, o_stall_n, o_stable, ak);
      end
    end
  endtask

  task automatic test_misalign();
    logic        ld [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  f3 [6] = '{3'b010, 3'b001, 3'b101, 3'b001, 3'b000, 3'b000};
    logic [31:0] ad [6] = '{32'h101, 32'h0FF, 32'h003, 32'h201, 32'h202, 32'h103};
    for (int i = 0; i < 6; i++) begin
      run_txn(ld[i], ~ld[i], f3[i], 5'd8, ad[i], $urandom, $urandom, 1);
      total++;
      if ({o_mis, o_req_seen, o_wb_en, o_pulse2} !== 4'b1000 || o_stall_n !== 0) begin
        bad++; $display("FAIL misalign[%0d] got mis=%b req=%b wb_en=%b pulse2=%b stall=%0d exp 1 0 0 0 0",
                        i, o_mis, o_req_seen, o_wb_en, o_pulse2, o_stall_n);
      end
    end
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 1'b0, 3'b010, 5'd3, 32'h500, 32'd0, 32'd0, 0);
    total++;
    if ({o_err, o_wb_en, o_req_end, o_pulse2} !== 4'b1000) begin
      bad++; $display("FAIL timeout got err=%b wb_en=%b req_end=%b pulse2=%b exp 1 0 0 0", o_err, o_wb_en, o_req_end, o_pulse2);
    end
    total++;
    if (o_stall_n !== TIMEOUT + 1 || o_stable !== 1'b1) begin
      bad++; $display("FAIL timeout_len got cycles=%0d stable=%b exp %0d 1", o_stall_n, o_stable, TIMEOUT + 1);
    end
    run_txn(1'b1, 1'b0, 3'b010, 5'd3, 32'h504, 32'd0, 32'hCAFE_F00D, TIMEOUT + 1);
    total++;
    if ({o_err, o_wb_en, o_wb_data} !== {1'b0, 1'b1, 32'hCAFE_F00D}) begin
      bad++; $display("FAIL ack_wins got err=%b wb_en=%b data=%h exp 0 1 cafef00d", o_err, o_wb_en, o_wb_data);
    end
    run_txn(1'b1, 1'b0, 3'b100, 5'd2, 32'h507, 32'd0, 32'h7F00_0000, TIMEOUT);
    total++;
    if ({o_err, o_wb_en, o_wb_data} !== {1'b0, 1'b1, 32'h0000_007F} || o_stall_n !== TIMEOUT) begin
      bad++; $display("FAIL ack_last got err=%b en=%b data=%h cycles=%0d exp 0 1 0000007f %0d", o_err, o_wb_en, o_wb_data, o_stall_n, TIMEOUT);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(posedge clk); #1;
    opc = {1'b0, 3'b010, 7'b0000011}; rd_in = 5'd4; rdd = 32'h400; lv = 1'b1; sv = 1'b0;
    bus.dmem_ack_i = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({bus.dmem_req_o, stall} !== 2'b11) begin
      bad++; $display("FAIL wait_entry got req=%b stall=%b exp 1 1", bus.dmem_req_o, stall);
    end
    rstl = 1'b0; #1;
    total++;
    if ({stall, bus.dmem_req_o, bus.dmem_we_o, bus.dmem_addr_o, bus.dmem_be_o,
         wb_en, mis, err, wb_rd, wb_data} !== '0) begin
      bad++; $display("FAIL reset_mid_wait got req=%b stall=%b addr=%h, required all 0", bus.dmem_req_o, stall, bus.dmem_addr_o);
    end
    @(posedge clk); #1;
    lv = 1'b0; opc = 11'd0; rd_in = 5'd0; rdd = 32'd0; rstl = 1'b1;
    run_txn(1'b0, 1'b1, 3'b010, 5'd0, 32'h001, 32'h0000_005A, 32'd0, 1);
    total++;
    if ({o_req, o_we, o_be, o_wdata, o_addr} !== {1'b1, 1'b1, 4'b0010, 32'h5A5A_5A5A, 32'h0}) begin
      bad++; $display("FAIL sb_after_reset got req=%b we=%b be=%b wdata=%h addr=%h exp 1 1 0010 5a5a5a5a 0", o_req, o_we, o_be, o_wdata, o_addr);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misalign();
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
